id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter DATA_W, default 16, datapath and instruction width.
REQ-002 Parameter NREGS, default 8, register count; index width is 3.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port instr_in  input  16  instruction word from the fetch stage's ROM output.
REQ-006 Port instr_valid  input  1  instr_in holds a real instruction this cycle.
REQ-007 Port flush  input  1  taken branch/jump; discard everything in this stage.
REQ-008 Port wb_en / wb_addr / wb_data  input  1/3/16  register write-back port.
REQ-009 Port pc_hold  output  1  fetch hold request, combinational; PC and ROM address freeze while high.
REQ-010 Port ex_valid  output  1  ID/EX register holds a real instruction.
REQ-011 Port ex_op  output  4  opcode.
REQ-012 Port ex_rd  output  3  destination register.
REQ-013 Port ex_a / ex_b  output  16/16  operand register values.
REQ-014 Port ex_imm  output  16  sign-extended immediate.
REQ-015 Port ex_reg_write / ex_mem_read / ex_mem_write / ex_branch / ex_jump  output  1 each  control bits.

Function
REQ-016 Fields: op[15:12], rd[11:9], rs[8:6], rt[5:3], imm6[5:0], imm12[11:0].
REQ-017 Opcode map:
- 0x0-0x7: R-type ALU; a=R[rs], b=R[rt]; reg_write.
- 0x8 ADDI, 0x9 LW: a=R[rs], imm=sext(imm6); reg_write; LW also mem_read.
- 0xA SW: a=R[rs], b=R[rd], imm=sext(imm6); mem_write.
- 0xB BEQ: a=R[rd], b=R[rs], imm=sext(imm6); branch.
- 0xC-0xE: NOP; valid, all controls 0.
- 0xF JMP: imm=sext(imm12); jump.
REQ-018 IF/ID register captures instr_in and instr_valid each edge unless held by a stall.
REQ-019 ID/EX register loads decoded IF/ID content each edge; latency from instr_in capture to ex_* is exactly one further edge.
REQ-020 Register file: NREGS x 16; R0 reads 0 and ignores writes; write at edge when wb_en=1.
REQ-021 Load-use stall: ID/EX valid LW with ex_rd!=0, matched by a source register of the IF/ID instruction.
- pc_hold=1 that cycle.
- IF/ID holds its value.
- ID/EX loads a bubble (ex_valid=0, all controls 0).
- Stall lasts exactly one cycle.
REQ-022 flush=1: IF/ID and ID/EX load invalid/bubble at that edge; pc_hold=0; flush beats stall.
REQ-023 Simultaneous wb_en with a read of the same register: see REQ-026/027.
REQ-024 Bubbles never assert reg_write, mem_read, mem_write, branch or jump.

Reset
REQ-025 reset=1 clears asynchronously:
- IF/ID valid and all ID/EX outputs to 0.
- pc_hold to 0.
- all registers to 0.
- operation resumes on the first edge after deassertion.
- reset mid-stall discards the stalled instruction.

Configuration
REQ-026 With ID_BYPASS_EN defined: a same-cycle write to a register being read forwards wb_data into ex_a/ex_b (R0 excepted).
REQ-027 Without ID_BYPASS_EN: reads return the pre-write value; software inserts spacing.

Structure
REQ-028 Package cpu_pkg holds the opcode enum, field bit positions, DATA_W, NREGS and the control-bit struct.
REQ-029 Register file is sub-module reg_file (2 read ports, 1 write port); decode and hazard logic stay in id_stage.

Verification
REQ-030 Reset, then R-type load: R1=5, R2=7; instr 0x0650 (op0 rd3 rs1 rt2) -> next edge ex_op=0, ex_rd=3, ex_a=5, ex_b=7, ex_reg_write=1.
REQ-031 ADDI 0x8A7F: op8, rd5, rs1, imm6=0x3F -> ex_imm=0xFFFF, ex_a=R1.
REQ-032 LW rd=2 followed by ADD using rs=2:
- pc_hold=1 for exactly one cycle.
- one bubble with ex_valid=0.
- the ADD then issues with correct operands.
REQ-033 flush asserted during a pending stall -> both registers invalid next edge; pc_hold=0.
REQ-034 Write-back plus read of the same register:
- wb R4=0x1234 while reading R4: ex_a=0x1234 with ID_BYPASS_EN, old value without.
- write to R0 -> R0 still reads 0.
REQ-035 Reset asserted mid-stream -> all ex_* and pc_hold go 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode definitions for the ID stage: widths, instruction field
// positions, the opcode map and the control-bit bundle.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int REG_AW = 3;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RD_HI = 11;
  localparam int RD_LO = 9;
  localparam int RS_HI = 8;
  localparam int RS_LO = 6;
  localparam int RT_HI = 5;
  localparam int RT_LO = 3;
  localparam int IMM6_W  = 6;
  localparam int IMM12_W = 12;

  typedef enum logic [3:0] {
    OP_R0   = 4'h0, OP_R1 = 4'h1, OP_R2 = 4'h2, OP_R3 = 4'h3,
    OP_R4   = 4'h4, OP_R5 = 4'h5, OP_R6 = 4'h6, OP_R7 = 4'h7,
    OP_ADDI = 4'h8,
    OP_LW   = 4'h9,
    OP_SW   = 4'hA,
    OP_BEQ  = 4'hB,
    OP_NOP0 = 4'hC, OP_NOP1 = 4'hD, OP_NOP2 = 4'hE,
    OP_JMP  = 4'hF
  } opcode_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// NREGS x DATA_W register file, two combinational read ports, one write port.
// R0 is hardwired to zero. Define ID_BYPASS_EN to forward same-cycle writes to reads.
module reg_file #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int AW     = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
`ifdef ID_BYPASS_EN
    if (we && (waddr == raddr_a)) rdata_a = wdata;
    if (we && (waddr == raddr_b)) rdata_b = wdata;
`endif
    // R0 wins over any forwarded write
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode stage: IF/ID register, decode, register-file read, load-use
// stall, flush, and the ID/EX register. Optional ID_BYPASS_EN forwards write-back data.
module id_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NREGS  = cpu_pkg::NREGS
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              instr_valid,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              pc_hold,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic [2:0]        ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jump
);
  import cpu_pkg::*;

  logic [DATA_W-1:0] ifid_instr;
  logic              ifid_valid;

  opcode_e           op;
  logic [2:0]        f_rd, f_rs, f_rt;
  logic [2:0]        ra_addr, rb_addr;
  logic              use_a, use_b;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic [DATA_W-1:0] dec_imm;
  ctrl_t             dec_ctrl;
  ctrl_t             ex_ctrl;
  logic              stall;

  assign op   = opcode_e'(ifid_instr[OP_HI:OP_LO]);
  assign f_rd = ifid_instr[RD_HI:RD_LO];
  assign f_rs = ifid_instr[RS_HI:RS_LO];
  assign f_rt = ifid_instr[RT_HI:RT_LO];

  always_comb begin
    ra_addr  = f_rs;
    rb_addr  = f_rt;
    use_a    = 1'b0;
    use_b    = 1'b0;
    dec_imm  = '0;
    dec_ctrl = '0;
    case (op)
      OP_R0, OP_R1, OP_R2, OP_R3, OP_R4, OP_R5, OP_R6, OP_R7: begin
        use_a = 1'b1;
        use_b = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        use_a   = 1'b1;
        dec_imm = {{(DATA_W-IMM6_W){ifid_instr[IMM6_W-1]}}, ifid_instr[IMM6_W-1:0]};
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.mem_read  = (op == OP_LW);
      end
      OP_SW: begin
        use_a   = 1'b1;
        use_b   = 1'b1;
        rb_addr = f_rd;
        dec_imm = {{(DATA_W-IMM6_W){ifid_instr[IMM6_W-1]}}, ifid_instr[IMM6_W-1:0]};
        dec_ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        use_a   = 1'b1;
        use_b   = 1'b1;
        ra_addr = f_rd;
        rb_addr = f_rs;
        dec_imm = {{(DATA_W-IMM6_W){ifid_instr[IMM6_W-1]}}, ifid_instr[IMM6_W-1:0]};
        dec_ctrl.branch = 1'b1;
      end
      OP_JMP: begin
        dec_imm = {{(DATA_W-IMM12_W){ifid_instr[IMM12_W-1]}}, ifid_instr[IMM12_W-1:0]};
        dec_ctrl.jump = 1'b1;
      end
      default: ;
    endcase
  end

  reg_file #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(REG_AW)) u_reg_file (
    .clock   (clock),
    .reset   (reset),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (ra_addr),
    .raddr_b (rb_addr),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Only operands the instruction actually reads can create a load-use hazard
  assign stall = ex_valid && (ex_op == OP_LW) && (ex_rd != 3'd0) && ifid_valid &&
                 ((use_a && (ra_addr == ex_rd)) || (use_b && (rb_addr == ex_rd)));
  assign pc_hold = stall && !flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ifid_instr <= '0;
      ifid_valid <= 1'b0;
      ex_valid   <= 1'b0;
      ex_op      <= '0;
      ex_rd      <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
    end else begin
      if (flush) begin
        ifid_valid <= 1'b0;
      end else if (!stall) begin
        ifid_instr <= instr_in;
        ifid_valid <= instr_valid;
      end

      if (flush || stall || !ifid_valid) begin
        ex_valid <= 1'b0;
        ex_op    <= '0;
        ex_rd    <= '0;
        ex_a     <= '0;
        ex_b     <= '0;
        ex_imm   <= '0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid <= 1'b1;
        ex_op    <= op;
        ex_rd    <= f_rd;
        ex_a     <= use_a ? rdata_a : '0;
        ex_b     <= use_b ? rdata_b : '0;
        ex_imm   <= dec_imm;
        ex_ctrl  <= dec_ctrl;
      end
    end
  end

  assign ex_reg_write = ex_ctrl.reg_write;
  assign ex_mem_read  = ex_ctrl.mem_read;
  assign ex_mem_write = ex_ctrl.mem_write;
  assign ex_branch    = ex_ctrl.branch;
  assign ex_jump      = ex_ctrl.jump;

endmodule
